// File: rtl/spi_adc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spi_adc_pkg
// Desc     : FSM state encoding and SPI frame bit-index constants shared by the
//            SPI ADC sequencer and its sub-modules.
// Rev      : 1.0  initial release
// ============================================================================
package spi_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_AMP_LOAD = 2'd1,
    ST_CONV     = 2'd2,
    ST_READ     = 2'd3
  } state_t;

  // Frame positions are 6-bit to match the shared bit counter width
  localparam logic [5:0] CH0_MSB_IDX = 6'd2;
  localparam logic [5:0] CH1_MSB_IDX = 6'd18;
  localparam logic [5:0] READ_BITS   = 6'd34;
  localparam logic [5:0] AMP_BITS    = 6'd8;
  localparam logic [5:0] SAMPLE_BITS = 6'd14;

  // True when a READ bit index falls inside a channel's 14-bit field
  function automatic logic in_field(input logic [5:0] idx, input logic [5:0] msb_idx);
    return (idx >= msb_idx) && (idx < (msb_idx + SAMPLE_BITS));
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_adc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface: spi_adc_sequencer_if
// Desc     : Sample hand-off from the ADC sequencer to the UART framer
//            (valid/ready, data held while valid).
// Rev      : 1.0  initial release
// ============================================================================
interface spi_adc_sequencer_if;
  logic [13:0] sample_ch0;
  logic [13:0] sample_ch1;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_ch0, output sample_ch1, output sample_valid,
                  input  sample_ready);
  modport slave  (input  sample_ch0, input  sample_ch1, input  sample_valid,
                  output sample_ready);
endinterface
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module   : spi_clk_gen
// Desc     : CLK_DIV tick divider and SPI_CLK generator. SPI_CLK only runs
//            while 'run' is high and idles low otherwise. rise/fall mark the
//            clk edge on which SPI_CLK is driven low->high / high->low.
// Rev      : 1.0  initial release
// ============================================================================
module spi_clk_gen #(
  parameter int CLK_DIV = 8
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  run,
  output logic spi_clk,
  output logic rise,
  output logic fall
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = run && (div_cnt == DIV_LAST);
  assign rise = tick && !spi_clk;
  assign fall = tick &&  spi_clk;

  // Divider restarts on every run so each transfer has identical timing
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt <= '0;
      spi_clk <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      spi_clk <= ~spi_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_adc_sequencer
// Desc     : Owner of the shared SPI bus to the LTC6912 preamp and LTC1407A
//            ADC. Programs the preamp gain after reset (and after gain_wr),
//            then runs periodic conversions and hands samples to the UART
//            path over a valid/ready interface.
// Config   : SPI_ADC_CH1_EN - when defined, channel 1 (frame bits 18-31) is
//            captured into sample_ch1; otherwise sample_ch1 is tied to 0.
// Rev      : 1.0  initial release
// ============================================================================
module spi_adc_sequencer
  import spi_adc_pkg::*;
#(
  parameter int         CLK_DIV       = 8,
  parameter int         SAMPLE_PERIOD = 2500,
  parameter logic [7:0] AMP_GAIN      = 8'h11
) (
  input  wire                        clk,
  input  wire                        rst,
  input  wire                        enable,
  input  wire  [7:0]                 gain_in,
  input  wire                        gain_wr,
  spi_adc_sequencer_if.master        smp,
  output logic                       busy,
  output logic [7:0]                 overrun_cnt,
  output logic                       MOSI,
  input  wire                        MISO,
  output logic                       SPI_CLK,
  output logic                       CS_AMP,
  output logic                       ADC_Conv
);

  localparam int               PER_W     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(SAMPLE_PERIOD - 1);
  localparam int               CONV_W    = $clog2(2 * CLK_DIV);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(2 * CLK_DIV - 1);

  state_t            state;
  logic [PER_W-1:0]  period_cnt;
  logic              expire;
  logic [CONV_W-1:0] conv_cnt;
  logic [5:0]        bit_cnt;
  logic [7:0]        gain_reg;
  logic              gain_pend;
  logic [7:0]        amp_sh;
  logic [7:0]        amp_word;
  logic [13:0]       ch0_sh;
  logic [13:0]       ch0_q;
  logic              valid_q;
  logic [7:0]        overrun_q;
  logic              spi_run;
  logic              sck_rise;
  logic              sck_fall;

  assign expire   = (period_cnt == PER_LAST);
  assign spi_run  = (state == ST_AMP_LOAD) || (state == ST_READ);
  // A strobe arriving with the expiry is honoured by that very load
  assign amp_word = gain_wr ? gain_in : gain_reg;
  assign busy     = (state != ST_IDLE);

  assign smp.sample_ch0   = ch0_q;
  assign smp.sample_valid = valid_q;
  assign overrun_cnt      = overrun_q;

`ifdef SPI_ADC_CH1_EN
  logic [13:0] ch1_sh;
  logic [13:0] ch1_q;
  assign smp.sample_ch1 = ch1_q;
`else
  assign smp.sample_ch1 = '0;
`endif

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .run     (spi_run),
    .spi_clk (SPI_CLK),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  // Free-running conversion period timer, independent of the FSM
  always_ff @(posedge clk) begin
    if (rst || expire) period_cnt <= '0;
    else               period_cnt <= period_cnt + 1'b1;
  end

  // Sequencer FSM: gain load, conversion pulse, frame read, sample hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      CS_AMP    <= 1'b1;
      MOSI      <= 1'b0;
      ADC_Conv  <= 1'b0;
      valid_q   <= 1'b0;
      ch0_q     <= '0;
      ch0_sh    <= '0;
      overrun_q <= '0;
      gain_reg  <= AMP_GAIN;
      gain_pend <= 1'b1;
      amp_sh    <= '0;
      bit_cnt   <= '0;
      conv_cnt  <= '0;
`ifdef SPI_ADC_CH1_EN
      ch1_q     <= '0;
      ch1_sh    <= '0;
`endif
    end else begin
      if (gain_wr) begin
        gain_reg  <= gain_in;
        gain_pend <= 1'b1;
      end
      if (valid_q && smp.sample_ready) valid_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (expire) begin
            if (gain_pend || gain_wr) begin
              state   <= ST_AMP_LOAD;
              CS_AMP  <= 1'b0;
              MOSI    <= amp_word[7];
              amp_sh  <= amp_word;
              bit_cnt <= '0;
            end else if (enable && !valid_q) begin
              state    <= ST_CONV;
              ADC_Conv <= 1'b1;
              conv_cnt <= '0;
            end else if (enable && (overrun_q != 8'hFF)) begin
              overrun_q <= overrun_q + 8'd1;
            end
          end
        end

        ST_AMP_LOAD: begin
          // The amp latched the current bit on the rise; present the next on the fall
          if (sck_rise) amp_sh <= {amp_sh[6:0], 1'b0};
          if (sck_fall) begin
            if (bit_cnt == (AMP_BITS - 6'd1)) begin
              state  <= ST_IDLE;
              CS_AMP <= 1'b1;
              MOSI   <= 1'b0;
              if (!gain_wr) gain_pend <= 1'b0;
            end else begin
              MOSI    <= amp_sh[7];
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        ST_CONV: begin
          if (conv_cnt == CONV_LAST) begin
            state    <= ST_READ;
            ADC_Conv <= 1'b0;
            bit_cnt  <= '0;
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end

        ST_READ: begin
          if (sck_fall) begin
            if (in_field(bit_cnt, CH0_MSB_IDX)) ch0_sh <= {ch0_sh[12:0], MISO};
`ifdef SPI_ADC_CH1_EN
            if (in_field(bit_cnt, CH1_MSB_IDX)) ch1_sh <= {ch1_sh[12:0], MISO};
`endif
            if (bit_cnt == (READ_BITS - 6'd1)) begin
              state   <= ST_IDLE;
              ch0_q   <= ch0_sh;
`ifdef SPI_ADC_CH1_EN
              ch1_q   <= ch1_sh;
`endif
              valid_q <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
